// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR stage and its downstream period monitor:
// LFSR geometry, monitor state encoding and active-low 7-segment codes.
package lfsr_pkg;

  localparam int unsigned LFSR_W   = 8;
  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned SEG_W    = 7;

  // Feedback taps of x^8 + x^4 + x^3 + x^2 + 1 (right-shifting Fibonacci form)
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    COUNT = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } mon_state_e;

  // Segment codes, bit order {g,f,e,d,c,b,a}, a lit segment is 0
  localparam logic [SEG_W-1:0] SEG_0 = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1 = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2 = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3 = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4 = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5 = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6 = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7 = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8 = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9 = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F = 7'b0001110;

  // One LFSR step: parity of the tapped bits enters at the MSB
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/seg7_hex_dec.sv
// Hex nibble to active-low 7-segment decoder, shared by the LFSR display and the monitor.
module seg7_hex_dec
  import lfsr_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the recurrence period of a sampled LFSR state word and flags lock-up
// (all-zero state) or a missing recurrence; shows period[7:0] on two hex digits.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH   = LFSR_W,
  parameter int unsigned CNT_W   = WIDTH + 1,
  parameter int unsigned TIMEOUT = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  output logic             busy,
  output logic             done,
  output logic             err_zero,
  output logic             err_timeout,
  output logic [CNT_W-1:0] period,
  output logic [SEG_W-1:0] hex_high,
  output logic [SEG_W-1:0] hex_low
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  mon_state_e       state_q, state_nx;
  logic [WIDTH-1:0] seed_q, seed_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [CNT_W-1:0] period_q, period_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             err_zero_q, err_zero_nx;
  logic             err_timeout_q, err_timeout_nx;

  logic [CNT_W-1:0] cnt_inc;
  logic             is_zero;
  logic             hit_seed;
  logic             hit_timeout;

  // Saturating step count; the counter never wraps past TIMEOUT
  assign cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign is_zero     = (sample == '0);
  assign hit_seed    = (sample == seed_q);
  assign hit_timeout = (cnt_inc == CNT_MAX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nx;
    end
  end

  // start overrides everything, including a sample presented in the same cycle
  always_comb begin
    state_nx = state_q;
    if (start) begin
      state_nx = ARM;
    end else if (sample_valid) begin
      case (state_q)
        ARM: begin
          state_nx = is_zero ? ERR : COUNT;
        end
        COUNT: begin
          if (hit_seed || is_zero || hit_timeout) begin
            state_nx = hit_seed ? DONE : ERR;
          end
        end
        default: state_nx = state_q;
      endcase
    end
  end

  always_comb begin
    seed_nx        = seed_q;
    cnt_nx         = cnt_q;
    period_nx      = period_q;
    done_nx        = done_q;
    err_zero_nx    = err_zero_q;
    err_timeout_nx = err_timeout_q;
    busy_nx        = (state_nx == ARM) || (state_nx == COUNT);

    if (start) begin
      done_nx        = 1'b0;
      err_zero_nx    = 1'b0;
      err_timeout_nx = 1'b0;
    end else if (sample_valid) begin
      case (state_q)
        ARM: begin
          seed_nx     = sample;
          cnt_nx      = '0;
          err_zero_nx = is_zero;
        end
        COUNT: begin
          cnt_nx = cnt_inc;
          if (hit_seed) begin
            period_nx = cnt_inc;
            done_nx   = 1'b1;
          end else if (is_zero) begin
            err_zero_nx = 1'b1;
          end else if (hit_timeout) begin
            err_timeout_nx = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seed_q        <= '0;
      cnt_q         <= '0;
      period_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_zero_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      seed_q        <= seed_nx;
      cnt_q         <= cnt_nx;
      period_q      <= period_nx;
      busy_q        <= busy_nx;
      done_q        <= done_nx;
      err_zero_q    <= err_zero_nx;
      err_timeout_q <= err_timeout_nx;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign err_zero    = err_zero_q;
  assign err_timeout = err_timeout_q;
  assign period      = period_q;

  seg7_hex_dec u_hex_high (
    .nibble (period_q[7:4]),
    .seg    (hex_high)
  );

  seg7_hex_dec u_hex_low (
    .nibble (period_q[3:0]),
    .seg    (hex_low)
  );

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Self-checking bench for lfsr_period_monitor: table of measurement runs scored
// through an expected-result queue, plus abort and asynchronous-reset sequences.
module tb_lfsr_period_monitor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       sample_valid;
  logic [7:0] sample;
  logic       busy, done, err_zero, err_timeout;
  logic [8:0] period;
  logic [6:0] hex_high, hex_low;

  always #5 clk = ~clk;

  lfsr_period_monitor dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .sample_valid (sample_valid),
    .sample       (sample),
    .busy         (busy),
    .done         (done),
    .err_zero     (err_zero),
    .err_timeout  (err_timeout),
    .period       (period),
    .hex_high     (hex_high),
    .hex_low      (hex_low)
  );

  localparam logic [6:0] SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam int K_LFSR = 0, K_ZSEED = 1, K_NOREP = 2, K_ZMID = 3, K_SHORT = 4;

  typedef struct {
    string      name;
    int         kind;
    bit         toggle;
    logic       exp_done;
    logic       exp_ez;
    logic       exp_et;
    logic [8:0] exp_period;
  } vec_t;

  typedef struct {
    string      name;
    logic       done;
    logic       ez;
    logic       et;
    logic [8:0] period;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  exp_t       sb[$];
  logic [7:0] seq[$];
  vec_t       vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge
  task automatic cyc(input logic st, input logic v, input logic [7:0] s);
    start        = st;
    sample_valid = v;
    sample       = s;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[4] ^ s[3] ^ s[2] ^ s[0], s[7:1]};
  endfunction

  function automatic vec_t mk(input string n, input int k, input bit t, input logic d,
                              input logic ez, input logic et, input logic [8:0] p);
    vec_t v;
    v.name = n; v.kind = k; v.toggle = t;
    v.exp_done = d; v.exp_ez = ez; v.exp_et = et; v.exp_period = p;
    return v;
  endfunction

  // Builds the sample stream for a run; the first entry is the seed
  task automatic gen_seq(input int kind);
    logic [7:0] s;
    seq.delete();
    case (kind)
      K_LFSR: begin
        s = 8'h01;
        seq.push_back(s);
        for (int i = 0; i < 255; i++) begin
          s = lfsr_step(s);
          seq.push_back(s);
        end
      end
      K_ZSEED: seq.push_back(8'h00);
      K_NOREP: begin
        seq.push_back(8'h01);
        for (int i = 0; i < 256; i++) seq.push_back(8'(2 + (i % 254)));
      end
      K_ZMID:  begin seq.push_back(8'h05); seq.push_back(8'h06);
                     seq.push_back(8'h07); seq.push_back(8'h00); end
      default: begin seq.push_back(8'h33); seq.push_back(8'h44);
                     seq.push_back(8'h55); seq.push_back(8'h33); end
    endcase
  endtask

  task automatic pop_and_check();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk({e.name, "_done"},     32'(done),        32'(e.done));
    chk({e.name, "_err_zero"}, 32'(err_zero),    32'(e.ez));
    chk({e.name, "_err_to"},   32'(err_timeout), 32'(e.et));
    chk({e.name, "_period"},   32'(period),      32'(e.period));
    chk({e.name, "_busy"},     32'(busy),        32'd0);
    chk({e.name, "_hex_hi"},   32'(hex_high),    32'(SEG[e.period[7:4]]));
    chk({e.name, "_hex_lo"},   32'(hex_low),     32'(SEG[e.period[3:0]]));
  endtask

  // Feeds the current seq (no start); pushes the expected outcome with the last sample
  task automatic feed(input string name, input bit toggle, input logic d, input logic ez,
                      input logic et, input logic [8:0] p);
    exp_t e;
    for (int i = 0; i < seq.size(); i++) begin
      if (i == seq.size() - 1) begin
        e.name = name; e.done = d; e.ez = ez; e.et = et; e.period = p;
        sb.push_back(e);
      end
      cyc(1'b0, 1'b1, seq[i]);
      if (i == seq.size() - 2 && seq.size() > 2) begin
        chk({name, "_pre_busy"}, 32'(busy), 32'd1);
        chk({name, "_pre_err"},  32'({err_zero, err_timeout, done}), 32'd0);
      end
      if (toggle && i != seq.size() - 1) cyc(1'b0, 1'b0, 8'h00);
    end
    pop_and_check();
  endtask

  task automatic arm(input string name);
    cyc(1'b1, 1'b0, 8'h00);
    chk({name, "_arm_busy"},  32'(busy), 32'd1);
    chk({name, "_arm_flags"}, 32'({done, err_zero, err_timeout}), 32'd0);
  endtask

  initial begin
    logic [8:0] prev;
    vt[0] = mk("lfsr",   K_LFSR,  1'b0, 1'b1, 1'b0, 1'b0, 9'd255);
    vt[1] = mk("zseed",  K_ZSEED, 1'b0, 1'b0, 1'b1, 1'b0, 9'd255);
    vt[2] = mk("zmid",   K_ZMID,  1'b0, 1'b0, 1'b1, 1'b0, 9'd255);
    vt[3] = mk("norep",  K_NOREP, 1'b0, 1'b0, 1'b0, 1'b1, 9'd255);
    vt[4] = mk("toggle", K_LFSR,  1'b1, 1'b1, 1'b0, 1'b0, 9'd255);
    vt[5] = mk("short",  K_SHORT, 1'b0, 1'b1, 1'b0, 1'b0, 9'd3);

    reset_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_status", 32'({busy, done, err_zero, err_timeout}), 32'd0);
    chk("rst_period", 32'(period), 32'd0);
    chk("rst_hex", 32'({hex_high, hex_low}), 32'({SEG[0], SEG[0]}));

    // IDLE ignores samples, even an all-zero one
    cyc(1'b0, 1'b1, 8'h00);
    chk("idle_ignore", 32'({busy, done, err_zero, err_timeout}), 32'd0);

    for (int v = 0; v < 6; v++) begin
      arm(vt[v].name);
      gen_seq(vt[v].kind);
      feed(vt[v].name, vt[v].toggle, vt[v].exp_done, vt[v].exp_ez,
           vt[v].exp_et, vt[v].exp_period);
      // Flags hold while further samples arrive
      cyc(1'b0, 1'b1, 8'h00);
      chk({vt[v].name, "_hold"}, 32'({done, err_zero, err_timeout}),
          32'({vt[v].exp_done, vt[v].exp_ez, vt[v].exp_et}));
    end

    // Abort mid-COUNT; the simultaneous zero sample must be discarded
    prev = period;
    arm("abort");
    gen_seq(K_LFSR);
    for (int i = 0; i < 40; i++) cyc(1'b0, 1'b1, seq[i]);
    chk("abort_busy_pre", 32'(busy), 32'd1);
    cyc(1'b1, 1'b1, 8'h00);
    chk("abort_busy", 32'(busy), 32'd1);
    chk("abort_flags", 32'({done, err_zero, err_timeout}), 32'd0);
    chk("abort_period", 32'(period), 32'(prev));
    feed("after_abort", 1'b0, 1'b1, 1'b0, 1'b0, 9'd255);

    // Asynchronous reset in the middle of a count
    arm("areset");
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, seq[i]);
    chk("areset_busy_pre", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_status", 32'({busy, done, err_zero, err_timeout}), 32'd0);
    chk("areset_period", 32'(period), 32'd0);
    chk("areset_hex", 32'({hex_high, hex_low}), 32'({SEG[0], SEG[0]}));
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc(1'b0, 1'b1, 8'h01);
    chk("post_reset_idle", 32'({busy, period}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound so the run always terminates
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
